mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single main-memory block port between the instruction-cache controller and the data-cache controller.
- Each requester holds its memory request at level until it sees its done pulse. The arbiter grants one requester at a time, uses round-robin on ties, and keeps the grant until that transaction completes.
- Sits between both cache controllers and the main memory model.
- Includes a per-transaction watchdog that reports a stalled memory.

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 92 +++++++++
 tb/tb_mem_arbiter.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared bus bundle between the two cache controllers, the arbiter and main memory.
// The slave view belongs to the arbiter. The master view belongs to whatever drives the caches and memory.
interface mem_arbiter_if #(
  parameter int unsigned BADDR_W    = 28,
  parameter int unsigned BLOCK_BITS = 128
);
  logic                  i_mem_ren;
  logic [BADDR_W-1:0]    i_block_addr;
  logic                  i_mem_read_ready;
  logic [BLOCK_BITS-1:0] i_mem_dout;

  logic                  d_mem_ren;
  logic                  d_mem_wen;
  logic [BADDR_W-1:0]    d_block_addr;
  logic [BLOCK_BITS-1:0] d_mem_din;
  logic                  d_mem_read_ready;
  logic                  d_mem_write_done;
  logic [BLOCK_BITS-1:0] d_mem_dout;

  logic                  mem_ren;
  logic                  mem_wen;
  logic [BADDR_W-1:0]    mem_block_addr;
  logic [BLOCK_BITS-1:0] mem_din;
  logic [BLOCK_BITS-1:0] mem_dout;
  logic                  mem_read_ready;
  logic                  mem_write_done;

  logic                  grant_i;
  logic                  grant_d;
  logic                  timeout_err;

  modport slave (
    input  i_mem_ren, i_block_addr,
    input  d_mem_ren, d_mem_wen, d_block_addr, d_mem_din,
    input  mem_dout, mem_read_ready, mem_write_done,
    output i_mem_read_ready, i_mem_dout,
    output d_mem_read_ready, d_mem_write_done, d_mem_dout,
    output mem_ren, mem_wen, mem_block_addr, mem_din,
    output grant_i, grant_d, timeout_err
  );

  modport master (
    output i_mem_ren, i_block_addr,
    output d_mem_ren, d_mem_wen, d_block_addr, d_mem_din,
    output mem_dout, mem_read_ready, mem_write_done,
    input  i_mem_read_ready, i_mem_dout,
    input  d_mem_read_ready, d_mem_write_done, d_mem_dout,
    input  mem_ren, mem_wen, mem_block_addr, mem_din,
    input  grant_i, grant_d, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one main-memory block port between the icache and the dcache.
// A grant is held until its transaction completes, and a watchdog guards each grant.
module mem_arbiter #(
  parameter int unsigned BADDR_W        = 28,
  parameter int unsigned BLOCK_BITS     = 128,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic           clock,
  input  logic           reset,
  mem_arbiter_if.slave   bus
);
  localparam bit          WD_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_d;
  logic [CNT_W-1:0] r_wd_cnt;
  logic             r_timeout_err;

  logic w_req_i;
  logic w_req_d;
  logic w_done;
  logic w_wd_fire;

  assign w_req_i   = bus.i_mem_ren;
  assign w_req_d   = bus.d_mem_ren | bus.d_mem_wen;
  assign w_done    = bus.mem_read_ready | bus.mem_write_done;
  // A done pulse in the final cycle wins over the watchdog.
  assign w_wd_fire = WD_EN && (r_state != IDLE) &&
                     (r_wd_cnt == CNT_W'(TO_LAST)) && !w_done;

  assign bus.i_mem_dout  = bus.mem_dout;
  assign bus.d_mem_dout  = bus.mem_dout;
  assign bus.grant_i     = (r_state == GRANT_I);
  assign bus.grant_d     = (r_state == GRANT_D);
  assign bus.timeout_err = r_timeout_err;

  // Next state and owner-steered forwarding of the memory port
  always_comb begin
    w_next               = r_state;
    bus.mem_ren          = 1'b0;
    bus.mem_wen          = 1'b0;
    bus.mem_block_addr   = '0;
    bus.mem_din          = '0;
    bus.i_mem_read_ready = 1'b0;
    bus.d_mem_read_ready = 1'b0;
    bus.d_mem_write_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req_i && w_req_d) w_next = r_last_d ? GRANT_I : GRANT_D;
        else if (w_req_d)       w_next = GRANT_D;
        else if (w_req_i)       w_next = GRANT_I;
      end
      GRANT_I: begin
        bus.mem_ren          = bus.i_mem_ren;
        bus.mem_block_addr   = bus.i_block_addr;
        bus.i_mem_read_ready = bus.mem_read_ready;
        if (w_done || !w_req_i || w_wd_fire) w_next = IDLE;
      end
      GRANT_D: begin
        // A writeback masks a simultaneous read; the refill comes as a later grant.
        bus.mem_ren          = bus.d_mem_ren & ~bus.d_mem_wen;
        bus.mem_wen          = bus.d_mem_wen;
        bus.mem_block_addr   = bus.d_block_addr;
        bus.mem_din          = bus.d_mem_din;
        bus.d_mem_read_ready = bus.mem_read_ready;
        bus.d_mem_write_done = bus.mem_write_done;
        if (w_done || !w_req_d || w_wd_fire) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_last_d      <= 1'b0;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == GRANT_D) r_last_d <= 1'b1;
      if (r_state == IDLE && w_next == GRANT_I) r_last_d <= 1'b0;
      r_wd_cnt <= (r_state == IDLE) ? '0 : r_wd_cnt + CNT_W'(1);
      if (w_wd_fire) r_timeout_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grant latency, round-robin ties, writeback/refill, watchdog, reset.
module tb_mem_arbiter;
  localparam int unsigned BADDR_W    = 28;
  localparam int unsigned BLOCK_BITS = 128;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  mem_arbiter_if #(.BADDR_W(BADDR_W), .BLOCK_BITS(BLOCK_BITS)) bus ();

  mem_arbiter #(
    .BADDR_W(BADDR_W), .BLOCK_BITS(BLOCK_BITS), .TIMEOUT_CYCLES(8), .CNT_W(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_inputs();
    bus.i_mem_ren      = 1'b0;
    bus.i_block_addr   = '0;
    bus.d_mem_ren      = 1'b0;
    bus.d_mem_wen      = 1'b0;
    bus.d_block_addr   = '0;
    bus.d_mem_din      = '0;
    bus.mem_dout       = '0;
    bus.mem_read_ready = 1'b0;
    bus.mem_write_done = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [BLOCK_BITS-1:0] pat;
    pat = {4{32'hA5A5_0F0F}};
    clear_inputs();
    reset = 1'b0;
    bus.mem_dout = pat;
    #12;
    checks++; if (bus.grant_i !== 1'b0 || bus.grant_d !== 1'b0) begin errors++; $display("FAIL reset_grants got i=%b d=%b want 0 0", bus.grant_i, bus.grant_d); end
    checks++; if (bus.mem_ren !== 1'b0 || bus.mem_wen !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL reset_mem got ren=%b wen=%b to=%b want 0 0 0", bus.mem_ren, bus.mem_wen, bus.timeout_err); end
    checks++; if (bus.mem_block_addr !== '0 || bus.mem_din !== '0) begin errors++; $display("FAIL reset_bus got addr=%h din=%h want 0", bus.mem_block_addr, bus.mem_din); end
    checks++; if (bus.i_mem_dout !== pat || bus.d_mem_dout !== pat) begin errors++; $display("FAIL reset_dout got i=%h d=%h want %h", bus.i_mem_dout, bus.d_mem_dout, pat); end
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  task automatic test_icache_read();
    logic [BLOCK_BITS-1:0] data;
    data = {32'h1111_2222, 32'h3333_4444, 32'h5555_6666, 32'h7777_8888};
    bus.i_mem_ren    = 1'b1;
    bus.i_block_addr = 28'h000_0123;
    #1;
    checks++; if (bus.grant_i !== 1'b0) begin errors++; $display("FAIL iread_latency got grant_i=%b want 0", bus.grant_i); end
    step();
    checks++; if (bus.grant_i !== 1'b1 || bus.mem_ren !== 1'b1) begin errors++; $display("FAIL iread_grant got grant_i=%b ren=%b want 1 1", bus.grant_i, bus.mem_ren); end
    checks++; if (bus.mem_block_addr !== 28'h000_0123 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL iread_addr got addr=%h wen=%b want 0000123 0", bus.mem_block_addr, bus.mem_wen); end
    step(3);
    checks++; if (bus.i_mem_read_ready !== 1'b0) begin errors++; $display("FAIL iread_early got rr=%b want 0", bus.i_mem_read_ready); end
    bus.mem_read_ready = 1'b1;
    bus.mem_dout       = data;
    #1;
    checks++; if (bus.i_mem_read_ready !== 1'b1 || bus.d_mem_read_ready !== 1'b0) begin errors++; $display("FAIL iread_done got i=%b d=%b want 1 0", bus.i_mem_read_ready, bus.d_mem_read_ready); end
    checks++; if (bus.i_mem_dout !== data) begin errors++; $display("FAIL iread_data got %h want %h", bus.i_mem_dout, data); end
    step();
    bus.mem_read_ready = 1'b0;
    bus.i_mem_ren      = 1'b0;
    #1;
    checks++; if (bus.grant_i !== 1'b0 || bus.mem_ren !== 1'b0 || bus.i_mem_read_ready !== 1'b0) begin errors++; $display("FAIL iread_release got grant=%b ren=%b rr=%b want 0 0 0", bus.grant_i, bus.mem_ren, bus.i_mem_read_ready); end
  endtask

  task automatic test_round_robin();
    logic exp_d;
    apply_reset();
    bus.i_mem_ren = 1'b1;
    bus.d_mem_ren = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = (k % 2 == 0);
      step();
      checks++; if (bus.grant_d !== exp_d || bus.grant_i !== !exp_d) begin errors++; $display("FAIL rr_tie%0d got d=%b i=%b want d=%b", k, bus.grant_d, bus.grant_i, exp_d); end
      bus.mem_read_ready = 1'b1;
      #1;
      checks++; if (bus.d_mem_read_ready !== exp_d || bus.i_mem_read_ready !== !exp_d) begin errors++; $display("FAIL rr_done%0d got d=%b i=%b want d=%b", k, bus.d_mem_read_ready, bus.i_mem_read_ready, exp_d); end
      step();
      bus.mem_read_ready = 1'b0;
      #1;
      checks++; if (bus.grant_d !== 1'b0 || bus.grant_i !== 1'b0 || bus.mem_ren !== 1'b0) begin errors++; $display("FAIL rr_gap%0d got d=%b i=%b ren=%b want 0 0 0", k, bus.grant_d, bus.grant_i, bus.mem_ren); end
    end
    clear_inputs();
    step();
  endtask

  task automatic test_writeback_refill();
    logic [BLOCK_BITS-1:0] wdata;
    wdata = {32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0123_4567, 32'h89AB_CDEF};
    bus.d_mem_wen    = 1'b1;
    bus.d_mem_din    = wdata;
    bus.d_block_addr = 28'h0AB_CDE0;
    step();
    bus.i_mem_ren    = 1'b1;
    bus.i_block_addr = 28'h000_0040;
    #1;
    checks++; if (bus.grant_d !== 1'b1 || bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0) begin errors++; $display("FAIL wb_grant got d=%b wen=%b ren=%b want 1 1 0", bus.grant_d, bus.mem_wen, bus.mem_ren); end
    checks++; if (bus.mem_din !== wdata || bus.mem_block_addr !== 28'h0AB_CDE0) begin errors++; $display("FAIL wb_bus got din=%h addr=%h want %h 0abcde0", bus.mem_din, bus.mem_block_addr, wdata); end
    bus.mem_write_done = 1'b1;
    #1;
    checks++; if (bus.d_mem_write_done !== 1'b1 || bus.d_mem_read_ready !== 1'b0) begin errors++; $display("FAIL wb_done got wd=%b rr=%b want 1 0", bus.d_mem_write_done, bus.d_mem_read_ready); end
    step();
    bus.mem_write_done = 1'b0;
    bus.d_mem_wen      = 1'b0;
    bus.d_mem_ren      = 1'b1;
    #1;
    checks++; if (bus.grant_d !== 1'b0 || bus.grant_i !== 1'b0 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL wb_gap got d=%b i=%b wen=%b want 0 0 0", bus.grant_d, bus.grant_i, bus.mem_wen); end
    step();
    checks++; if (bus.grant_i !== 1'b1 || bus.mem_block_addr !== 28'h000_0040) begin errors++; $display("FAIL wb_icache_next got i=%b addr=%h want 1 0000040", bus.grant_i, bus.mem_block_addr); end
    bus.mem_read_ready = 1'b1;
    step();
    bus.mem_read_ready = 1'b0;
    bus.i_mem_ren      = 1'b0;
    step();
    checks++; if (bus.grant_d !== 1'b1 || bus.mem_ren !== 1'b1 || bus.mem_wen !== 1'b0) begin errors++; $display("FAIL wb_refill got d=%b ren=%b wen=%b want 1 1 0", bus.grant_d, bus.mem_ren, bus.mem_wen); end
    bus.mem_read_ready = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_write_masks_read();
    bus.d_mem_ren = 1'b1;
    bus.d_mem_wen = 1'b1;
    step();
    checks++; if (bus.grant_d !== 1'b1 || bus.mem_wen !== 1'b1 || bus.mem_ren !== 1'b0) begin errors++; $display("FAIL rw_mask got d=%b wen=%b ren=%b want 1 1 0", bus.grant_d, bus.mem_wen, bus.mem_ren); end
    bus.mem_write_done = 1'b1;
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_watchdog();
    apply_reset();
    bus.d_mem_ren = 1'b1;
    step();
    step(7);
    checks++; if (bus.grant_d !== 1'b1 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL wd_cycle8 got d=%b to=%b want 1 0", bus.grant_d, bus.timeout_err); end
    step();
    checks++; if (bus.grant_d !== 1'b0 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL wd_fire got d=%b to=%b want 0 1", bus.grant_d, bus.timeout_err); end
    step();
    checks++; if (bus.grant_d !== 1'b1 || bus.timeout_err !== 1'b1) begin errors++; $display("FAIL wd_regrant got d=%b to=%b want 1 1", bus.grant_d, bus.timeout_err); end
    apply_reset();
    bus.d_mem_ren = 1'b1;
    step();
    step(7);
    bus.mem_read_ready = 1'b1;
    #1;
    checks++; if (bus.d_mem_read_ready !== 1'b1) begin errors++; $display("FAIL wd_lastdone got rr=%b want 1", bus.d_mem_read_ready); end
    step();
    bus.mem_read_ready = 1'b0;
    bus.d_mem_ren      = 1'b0;
    #1;
    checks++; if (bus.timeout_err !== 1'b0 || bus.grant_d !== 1'b0) begin errors++; $display("FAIL wd_done_wins got to=%b d=%b want 0 0", bus.timeout_err, bus.grant_d); end
    step();
  endtask

  task automatic test_reset_mid_read();
    bus.d_mem_ren = 1'b1;
    step();
    checks++; if (bus.grant_d !== 1'b1 || bus.mem_ren !== 1'b1) begin errors++; $display("FAIL mid_pre got d=%b ren=%b want 1 1", bus.grant_d, bus.mem_ren); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (bus.mem_ren !== 1'b0 || bus.grant_d !== 1'b0 || bus.timeout_err !== 1'b0) begin errors++; $display("FAIL mid_reset got ren=%b d=%b to=%b want 0 0 0", bus.mem_ren, bus.grant_d, bus.timeout_err); end
    clear_inputs();
    @(negedge clock);
    reset = 1'b1;
    step();
    bus.mem_read_ready = 1'b1;
    bus.mem_write_done = 1'b1;
    #1;
    checks++; if (bus.i_mem_read_ready !== 1'b0 || bus.d_mem_read_ready !== 1'b0 || bus.d_mem_write_done !== 1'b0) begin errors++; $display("FAIL spurious got i=%b d=%b wd=%b want 0 0 0", bus.i_mem_read_ready, bus.d_mem_read_ready, bus.d_mem_write_done); end
    step();
    checks++; if (bus.grant_i !== 1'b0 || bus.grant_d !== 1'b0) begin errors++; $display("FAIL spurious_idle got i=%b d=%b want 0 0", bus.grant_i, bus.grant_d); end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_icache_read();
    test_round_robin();
    test_writeback_refill();
    test_write_masks_read();
    test_watchdog();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
